// File: rtl/irq_router_pkg.sv
// irq_router_pkg
//   Shared types and helpers for the interrupt priority router.
//   irq_state_t : grant FSM states (IDLE waits for pending work, BUSY holds a word)
//   id_w()      : channel-index width, never below 1 bit
package irq_router_pkg;

  typedef enum logic {IDLE, BUSY} irq_state_t;

  function automatic int id_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_priority_router_if.sv
// irq_priority_router_if
//   Valid/ready output port carrying the routed word.
//   out_valid : word available
//   out_ready : consumer accepts the word when out_valid && out_ready
//   out_data  : captured data of the granted channel
//   out_id    : index of the granted channel
//   master    : router side, slave : consumer side
interface irq_priority_router_if
  import irq_router_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DW   = 8
);
  localparam int IW = id_w(N_CH);

  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_id;

  modport master (output out_valid, output out_data, output out_id, input out_ready);
  modport slave  (input out_valid, input out_data, input out_id, output out_ready);
endinterface

// File: rtl/irq_prio_pick.sv
// irq_prio_pick
//   Combinational picker: first set bit of pending, searching upward from
//   start and wrapping at N_CH-1. With start tied to 0 this is plain
//   lowest-index-wins priority.
//   pending : request bits
//   start   : first index examined
//   win     : selected index (0 when nothing is pending)
//   any     : at least one request present
module irq_prio_pick
  import irq_router_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int IW   = id_w(N_CH)
) (
  input  logic [N_CH-1:0] pending,
  input  logic [IW-1:0]   start,
  output logic [IW-1:0]   win,
  output logic            any
);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = IW'((int'(start) + k) % N_CH);
      if (!found && pending[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |pending;

endmodule

// File: rtl/irq_priority_router.sv
// irq_priority_router
//   Turns rising edges on N_CH interrupt lines into pending bits and routes
//   one pending channel at a time (with its data word) to a valid/ready port.
//   Re-requests on a still-pending channel and multi-edge cycles are flagged.
//   Build option: define IRQ_ROUND_ROBIN_EN for a round-robin arbiter;
//   otherwise fixed priority, lowest index wins.
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   interrupt      : request lines, bit i = channel i
//   data_i         : per-channel data, sampled at grant time
//   pending_o      : current pending bits
//   overrun_o      : sticky, edge arrived while the channel was already pending
//   collision_o    : 1-cycle pulse, more than one edge seen in one cycle
//   collision_cnt  : saturating count of collision_o pulses
//   clr_i          : synchronous clear of overrun_o and collision_cnt
//   out_if         : valid/ready output port (master side)
module irq_priority_router
  import irq_router_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DW    = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_CH-1:0]          interrupt,
  input  logic [N_CH-1:0][DW-1:0]  data_i,
  output logic [N_CH-1:0]          pending_o,
  output logic [N_CH-1:0]          overrun_o,
  output logic                     collision_o,
  output logic [CNT_W-1:0]         collision_cnt,
  input  logic                     clr_i,
  irq_priority_router_if.master    out_if
);

  localparam int IW = id_w(N_CH);

  logic [N_CH-1:0]  irq_q, pending, overrun, rise, hs_mask;
  logic             collision_q;
  logic [CNT_W-1:0] coll_cnt;
  irq_state_t       state, state_nxt;
  logic             valid_q, valid_nxt;
  logic [DW-1:0]    data_q, data_nxt;
  logic [IW-1:0]    id_q, id_nxt, start, win;
  logic             any, hs;

  assign rise    = interrupt & ~irq_q;
  assign hs      = valid_q & out_if.out_ready;
  assign hs_mask = hs ? (N_CH'(1) << id_q) : '0;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [IW-1:0] rr_ptr, rr_nxt;

  always_comb begin
    rr_nxt = rr_ptr;
    if (hs) rr_nxt = (id_q == IW'(N_CH - 1)) ? '0 : id_q + IW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_nxt;
  end

  assign start = rr_ptr;
`else
  assign start = '0;
`endif

  irq_prio_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .pending (pending),
    .start   (start),
    .win     (win),
    .any     (any)
  );

  // A rise in the same cycle as the handshake re-arms the bit, so the
  // handshake mask is applied before the new edges are OR-ed in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q       <= '0;
      pending     <= '0;
      overrun     <= '0;
      collision_q <= 1'b0;
      coll_cnt    <= '0;
    end else begin
      irq_q       <= interrupt;
      pending     <= (pending & ~hs_mask) | rise;
      collision_q <= ($countones(rise) > 1);
      if (clr_i) begin
        overrun  <= '0;
        coll_cnt <= '0;
      end else begin
        overrun <= overrun | (rise & pending & ~hs_mask);
        if (collision_q && (coll_cnt != '1)) coll_cnt <= coll_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state   <= state_nxt;
      valid_q <= valid_nxt;
      data_q  <= data_nxt;
      id_q    <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = valid_q;
    data_nxt  = data_q;
    id_nxt    = id_q;
    case (state)
      IDLE: begin
        if (any) begin
          data_nxt  = data_i[win];
          id_nxt    = win;
          valid_nxt = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (hs) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_id    = id_q;
  assign pending_o        = pending;
  assign overrun_o        = overrun;
  assign collision_o      = collision_q;
  assign collision_cnt    = coll_cnt;

endmodule

// File: tb/tb_irq_priority_router.sv
module tb_irq_priority_router;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      interrupt;
  logic [3:0][7:0] data_i;
  logic [3:0]      pending_o, overrun_o;
  logic            collision_o;
  logic [7:0]      collision_cnt;
  logic            clr_i;

  int n_chk = 0;
  int n_err = 0;

  irq_priority_router_if #(.N_CH(4), .DW(8)) out_if ();

  irq_priority_router #(.N_CH(4), .DW(8), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .interrupt     (interrupt),
    .data_i        (data_i),
    .pending_o     (pending_o),
    .overrun_o     (overrun_o),
    .collision_o   (collision_o),
    .collision_cnt (collision_cnt),
    .clr_i         (clr_i),
    .out_if        (out_if.master)
  );

  always #5 clk = ~clk;

  // reference model: per-channel flags plus the word on offer
  bit m_prev [4];
  bit m_pend [4];
  bit m_ovr  [4];
  bit m_coll;
  int m_cnt;
  bit m_valid;
  int m_data, m_id, m_rr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input bit a [4]);
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_ovr[i] = 0;
    end
    m_coll = 0; m_cnt = 0; m_valid = 0; m_data = 0; m_id = 0; m_rr = 0;
  endtask

  // One clock of the rules: edges become requests, one word offered at a time.
  task automatic model_step();
    bit rise [4];
    bit taken [4];
    bit old_pend [4];
    int nrise = 0;
    bit hs = m_valid && out_if.out_ready;
    int start, w;
    for (int i = 0; i < 4; i++) begin
      rise[i]     = interrupt[i] && !m_prev[i];
      taken[i]    = hs && (m_id == i);
      old_pend[i] = m_pend[i];
      nrise       += rise[i] ? 1 : 0;
    end
    if (clr_i) m_cnt = 0;
    else if (m_coll && m_cnt < 255) m_cnt = m_cnt + 1;
    m_coll = (nrise > 1);
    for (int i = 0; i < 4; i++) begin
      if (clr_i) m_ovr[i] = 0;
      else if (rise[i] && old_pend[i] && !taken[i]) m_ovr[i] = 1;
      m_pend[i] = (old_pend[i] && !taken[i]) || rise[i];
      m_prev[i] = interrupt[i];
    end
    if (!m_valid) begin
`ifdef IRQ_ROUND_ROBIN_EN
      start = m_rr;
`else
      start = 0;
`endif
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && old_pend[(start + k) % 4]) w = (start + k) % 4;
      if (w >= 0) begin
        m_valid = 1; m_id = w; m_data = int'(data_i[w]);
      end
    end else if (hs) begin
      m_valid = 0;
      m_rr    = (m_id + 1) % 4;
    end
  endtask

  task automatic compare_all();
    chk("out_valid", {31'b0, out_if.out_valid}, {31'b0, m_valid});
    chk("out_data", {24'b0, out_if.out_data}, m_data);
    chk("out_id", {30'b0, out_if.out_id}, m_id);
    chk("pending", {28'b0, pending_o}, pk(m_pend));
    chk("overrun", {28'b0, overrun_o}, pk(m_ovr));
    chk("collision", {31'b0, collision_o}, {31'b0, m_coll});
    chk("coll_cnt", {24'b0, collision_cnt}, m_cnt);
  endtask

  // called at a falling edge; drives inputs, advances one clock, checks
  task automatic step(input logic [3:0] irq, input bit rdy, input bit clr);
    interrupt        = irq;
    out_if.out_ready = rdy;
    clr_i            = clr;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int grants[$];
    int first;
    rst_n = 1'b0; interrupt = '0; clr_i = 1'b0; out_if.out_ready = 1'b0;
    data_i = {8'h04, 8'h03, 8'h02, 8'h01};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'b0, out_if.out_valid}, 0);
    chk("rst_pending", {28'b0, pending_o}, 0);
    compare_all();
    rst_n = 1'b1;

    // 1: single edge on ch1, two-cycle latency
    step(4'b0000, 1, 0);
    step(4'b0010, 1, 0);
    chk("t1_pending", {28'b0, pending_o}, 32'h2);
    step(4'b0010, 1, 0);
    chk("t1_valid", {31'b0, out_if.out_valid}, 1);
    chk("t1_id", {30'b0, out_if.out_id}, 1);
    chk("t1_data", {24'b0, out_if.out_data}, 32'h02);
    step(4'b0010, 1, 0);
    chk("t1_pend_clr", {28'b0, pending_o}, 0);
    step(4'b0000, 1, 0);

    // 2: all four lines rise together
    step(4'b1111, 1, 0);
    chk("t2_pulse", {31'b0, collision_o}, 1);
    for (int s = 0; s < 10; s++) begin
      if (out_if.out_valid) grants.push_back(int'(out_if.out_id));
      step(4'b1111, 1, 0);
      if (s == 0) chk("t2_cnt", {24'b0, collision_cnt}, 1);
    end
`ifdef IRQ_ROUND_ROBIN_EN
    first = 2;
`else
    first = 0;
`endif
    chk("t2_ngrants", grants.size(), 4);
    for (int k = 0; k < 4 && k < grants.size(); k++)
      chk("t2_order", grants[k], (first + k) % 4);

    // 3: stalled word on ch2 stays frozen; re-pulse gives overrun
    step(4'b0000, 0, 0);
    step(4'b0100, 0, 0);
    step(4'b0100, 0, 0);
    chk("t3_id", {30'b0, out_if.out_id}, 2);
    data_i[2] = 8'hAA;
    step(4'b0100, 0, 0);
    chk("t3_hold", {24'b0, out_if.out_data}, 32'h03);
    step(4'b0000, 0, 0);
    step(4'b0100, 0, 0);
    chk("t3_overrun", {28'b0, overrun_o}, 32'h4);
    step(4'b0000, 1, 0);
    step(4'b0000, 1, 0);
    data_i[2] = 8'h03;
    repeat (3) step(4'b0000, 1, 0);

`ifdef IRQ_ROUND_ROBIN_EN
    // 4: after ch0 is served, ch2 beats ch0
    step(4'b0001, 1, 0);
    step(4'b0001, 1, 0);
    chk("t4_id0", {30'b0, out_if.out_id}, 0);
    step(4'b0000, 1, 0);
    step(4'b0101, 0, 0);
    step(4'b0101, 0, 0);
    chk("t4_rr", {30'b0, out_if.out_id}, 2);
    step(4'b0000, 1, 0);
    repeat (4) step(4'b0000, 1, 0);
`endif

    // 5: asynchronous reset while a word is on offer
    step(4'b0011, 0, 0);
    step(4'b0000, 0, 0);
    step(4'b0001, 0, 0);
    chk("t5_busy", {31'b0, out_if.out_valid}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid", {31'b0, out_if.out_valid}, 0);
    chk("t5_pending", {28'b0, pending_o}, 0);
    chk("t5_overrun", {28'b0, overrun_o}, 0);
    chk("t5_cnt", {24'b0, collision_cnt}, 0);
    model_reset();
    interrupt = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();

    // 6: counter saturation, then clear
    for (int s = 0; s < 260; s++) begin
      step(4'b0011, 1, 0);
      step(4'b0000, 1, 0);
    end
    step(4'b0000, 1, 0);
    chk("t6_sat", {24'b0, collision_cnt}, 32'hFF);
    step(4'b0000, 1, 1);
    chk("t6_clr_cnt", {24'b0, collision_cnt}, 0);
    chk("t6_clr_ovr", {28'b0, overrun_o}, 0);
    repeat (6) step(4'b0000, 1, 0);

    // randomized traffic against the model
    for (int s = 0; s < 1500; s++) begin
      logic [3:0] nirq;
      if ($urandom_range(0, 7) == 0) begin
        int j = $urandom_range(0, 3);
        data_i[j] = 8'($urandom);
      end
      nirq = interrupt ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
      step(nirq, $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
